// File: rtl/render_pkg.sv
// render_pkg: shared constants and types for the render scheduler slice.
//   SIZE          - float word width of one scene object field
//   NUM_CYLINDERS - number of cylinder objects in the scene
//   OBJ_FIELDS    - fields per scene object
//   H_ACTIVE      - default pixels per line
//   V_ACTIVE      - default lines per frame
//   obj_t         - one scene object, OBJ_FIELDS packed float words
//   state_t       - scheduler frame states
package render_pkg;

  localparam int SIZE          = 64;
  localparam int NUM_CYLINDERS = 10;
  localparam int OBJ_FIELDS    = 6;
  localparam int H_ACTIVE      = 320;
  localparam int V_ACTIVE      = 180;

  typedef logic [OBJ_FIELDS-1:0][SIZE-1:0] obj_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/render_scheduler_raster_counter.sv
// raster_counter: raster-order pixel coordinate generator.
//   aclk     - clock
//   aresetn  - synchronous active-low reset, zeroes both coordinates
//   clear    - return to (0,0) at the start of a frame
//   advance  - step to the next pixel in raster order
//   hcount   - current column
//   vcount   - current line
//   last     - current coordinate is the final pixel of the frame
module raster_counter
  import render_pkg::*;
#(
  parameter int H_ACTIVE = render_pkg::H_ACTIVE,
  parameter int V_ACTIVE = render_pkg::V_ACTIVE
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic        advance,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        last
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  assign last = (hcount == H_LAST) && (vcount == V_LAST);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (clear) begin
      hcount <= '0;
      vcount <= '0;
    end else if (advance) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// render_scheduler: issues one frame of pixel coordinates to a pipelined
// renderer, limiting the number of pixels in flight, and holds the scene
// objects stable for the whole frame.
//   aclk, aresetn            - clock, synchronous active-low reset
//   start                    - frame request pulse (honoured only when idle)
//   busy, frame_done         - frame in progress / one-cycle completion pulse
//   sphere_in, cylinders_in  - live scene objects
//   sphere_out, cylinders_out- scene objects latched at frame start
//   hcount_axis_*, vcount_axis_* - coordinate streams, always beat together
//   pixel_ret                - one pixel accepted at renderer output
//   inflight                 - pixels issued but not yet returned
//   ret_error                - sticky: a return arrived with nothing in flight
module render_scheduler
  import render_pkg::*;
#(
  parameter int SIZE         = render_pkg::SIZE,
  parameter int H_ACTIVE     = render_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = render_pkg::V_ACTIVE,
  parameter int MAX_INFLIGHT = 512
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 frame_done,
  input  logic [5:0][SIZE-1:0]                 sphere_in,
  input  logic [9:0][5:0][SIZE-1:0]            cylinders_in,
  output logic [5:0][SIZE-1:0]                 sphere_out,
  output logic [9:0][5:0][SIZE-1:0]            cylinders_out,
  output logic [10:0]                          hcount_axis_tdata,
  output logic                                 hcount_axis_tvalid,
  input  logic                                 hcount_axis_tready,
  output logic [9:0]                           vcount_axis_tdata,
  output logic                                 vcount_axis_tvalid,
  input  logic                                 vcount_axis_tready,
  input  logic                                 pixel_ret,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic                                 ret_error
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  state_t        state, state_next;
  logic          tvalid, tvalid_next;
  logic [IW-1:0] inflight_next;
  logic          beat, last, latch;

  // Both streams share one valid so the renderer always sees a matched pair.
  assign beat  = tvalid & hcount_axis_tready & vcount_axis_tready;
  assign latch = (state == IDLE) && start;

  assign busy               = (state != IDLE);
  assign hcount_axis_tvalid = tvalid;
  assign vcount_axis_tvalid = tvalid;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (latch),
    .advance (beat),
    .hcount  (hcount_axis_tdata),
    .vcount  (vcount_axis_tdata),
    .last    (last)
  );

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (beat && last) state_next = DRAIN;
      DRAIN: begin
        if (inflight == '0) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A return with nothing outstanding cannot lower the count below zero.
  always_comb begin
    inflight_next = inflight;
    if (beat && !pixel_ret) begin
      inflight_next = inflight + IW'(1);
    end else if (!beat && pixel_ret && (inflight != '0)) begin
      inflight_next = inflight - IW'(1);
    end
  end

  // Valid is only raised from within ISSUE, giving one idle cycle after
  // start. Without a beat the count cannot grow, so an asserted valid
  // naturally holds until it is accepted.
  assign tvalid_next = (state == ISSUE) && (state_next == ISSUE) &&
                       (inflight_next < IW'(MAX_INFLIGHT));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      tvalid        <= 1'b0;
      inflight      <= '0;
      ret_error     <= 1'b0;
      sphere_out    <= '0;
      cylinders_out <= '0;
    end else begin
      state    <= state_next;
      tvalid   <= tvalid_next;
      inflight <= inflight_next;
      if (pixel_ret && (inflight == '0)) begin
        ret_error <= 1'b1;
      end
      if (latch) begin
        sphere_out    <= sphere_in;
        cylinders_out <= cylinders_in;
      end
    end
  end

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: randomized self-checking bench for render_scheduler
// on a 4x3 raster with five pixels of credit. A small renderer model
// returns each issued pixel a fixed number of cycles after its beat.
module tb_render_scheduler;
  import render_pkg::*;

  localparam int H     = 4;
  localparam int V     = 3;
  localparam int MAXI  = 5;
  localparam int TOTAL = H * V;
  localparam int IW    = $clog2(MAXI + 1);

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic              busy;
  logic              frame_done;
  obj_t              sphere_in, sphere_out;
  obj_t [9:0]        cylinders_in, cylinders_out;
  logic [10:0]       hcount_axis_tdata;
  logic              hcount_axis_tvalid;
  logic              hready;
  logic [9:0]        vcount_axis_tdata;
  logic              vcount_axis_tvalid;
  logic              vready;
  logic              pixel_ret;
  logic [IW-1:0]     inflight;
  logic              ret_error;

  render_scheduler #(
    .H_ACTIVE     (H),
    .V_ACTIVE     (V),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .start              (start),
    .busy               (busy),
    .frame_done         (frame_done),
    .sphere_in          (sphere_in),
    .cylinders_in       (cylinders_in),
    .sphere_out         (sphere_out),
    .cylinders_out      (cylinders_out),
    .hcount_axis_tdata  (hcount_axis_tdata),
    .hcount_axis_tvalid (hcount_axis_tvalid),
    .hcount_axis_tready (hready),
    .vcount_axis_tdata  (vcount_axis_tdata),
    .vcount_axis_tvalid (vcount_axis_tvalid),
    .vcount_axis_tready (vready),
    .pixel_ret          (pixel_ret),
    .inflight           (inflight),
    .ret_error          (ret_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // stimulus knobs
  int ready_pct;
  int ret_delay;
  bit stall_en, stall_done, rand_start, start_req, rst_req, force_ret;
  bit rst_at_11, rst_done, checking;
  int stall_left;

  // reference model state
  bit          model_busy;
  int          model_inflight;
  bit          model_err;
  int          beats_done;
  obj_t        exp_sphere;
  obj_t [9:0]  exp_cyl;
  int          ret_q[$];
  bit          prev_valid, prev_beat;
  logic [20:0] prev_data;
  int          fd_count;
  int          peak;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic obj_t randObj();
    obj_t o;
    for (int f = 0; f < OBJ_FIELDS; f++) o[f] = {$urandom, $urandom};
    return o;
  endfunction

  // One clock: observe outputs just after the edge, drive this cycle's
  // inputs, check against the model, then advance the model to what the
  // next edge must produce.
  task automatic tick();
    logic        beat, fd_exp, hv;
    logic [20:0] coord;
    int          pre_inf;
    @(posedge aclk);
    #1;
    cyc++;
    hv    = hcount_axis_tvalid;
    coord = {hcount_axis_tdata, vcount_axis_tdata};

    sphere_in = randObj();
    for (int i = 0; i < NUM_CYLINDERS; i++) cylinders_in[i] = randObj();

    if (stall_en && !stall_done && hv && coord == {11'd2, 10'd1}) begin
      stall_left = 3;
      stall_done = 1;
    end
    if (stall_left > 0) begin
      hready = 1'b0;
      vready = 1'b0;
      stall_left--;
    end else begin
      hready = ($urandom_range(99) < ready_pct);
      vready = ($urandom_range(99) < ready_pct);
    end

    pixel_ret = force_ret || (ret_q.size() > 0 && ret_q[0] <= cyc);
    if (!force_ret && pixel_ret) void'(ret_q.pop_front());

    start = start_req || (rand_start && model_busy && $urandom_range(3) == 0);

    aresetn = 1'b1;
    if (rst_req) aresetn = 1'b0;
    if (rst_at_11 && !rst_done && hv && coord == {11'd1, 10'd1}) begin
      aresetn  = 1'b0;
      rst_done = 1;
    end

    fd_exp = model_busy && beats_done == TOTAL && model_inflight == 0;
    beat   = hv && hready && vready && aresetn;

    if (checking) begin
      checkOutput("busy", busy, model_busy);
      checkOutput("inflight", inflight, model_inflight);
      checkOutput("ret_error", ret_error, model_err);
      checkOutput("frame_done", frame_done, fd_exp);
      checkOutput("sphere_out", sphere_out == exp_sphere, 1);
      checkOutput("cylinders_out", cylinders_out == exp_cyl, 1);
      checkOutput("tvalid_pair", vcount_axis_tvalid, hv);
      if (!model_busy || beats_done == TOTAL) checkOutput("tvalid_off", hv, 0);
      if (hv) checkOutput("tvalid_credit", model_inflight < MAXI, 1);
      if (prev_valid && !prev_beat) begin
        checkOutput("tvalid_hold", hv, 1);
        checkOutput("tdata_hold", coord, prev_data);
      end
      if (beat)
        checkOutput("beat_coord", coord,
                    {11'(beats_done % H), 10'(beats_done / H)});
    end
    if (frame_done === 1'b1) fd_count++;
    if (inflight > peak) peak = int'(inflight);

    if (!aresetn) begin
      model_busy     = 0;
      model_inflight = 0;
      model_err      = 0;
      beats_done     = 0;
      exp_sphere     = '0;
      exp_cyl        = '0;
      ret_q.delete();
      prev_valid     = 0;
      prev_beat      = 0;
    end else begin
      pre_inf = model_inflight;
      if (pixel_ret && pre_inf == 0) model_err = 1;
      if (beat && !pixel_ret) model_inflight++;
      else if (!beat && pixel_ret && pre_inf > 0) model_inflight--;
      if (beat) begin
        beats_done++;
        ret_q.push_back(cyc + ret_delay);
      end
      if (fd_exp) begin
        model_busy = 0;
      end else if (start && !model_busy) begin
        model_busy = 1;
        beats_done = 0;
        exp_sphere = sphere_in;
        exp_cyl    = cylinders_in;
      end
      prev_valid = hv;
      prev_beat  = beat;
      prev_data  = coord;
    end
  endtask

  // Run one frame: start pulse, first-pixel latency, then let it drain.
  // With rst_mid the frame is abandoned by a reset at pixel (1,1).
  task automatic applyStimulus(input int pct, input int delay, input bit stall,
                               input bit rstart, input bit rst_mid);
    int fd_before;
    int n;
    ready_pct  = pct;
    ret_delay  = delay;
    stall_en   = stall;
    stall_done = 0;
    stall_left = 0;
    rand_start = 0;
    rst_at_11  = 0;
    rst_done   = 0;
    fd_before  = fd_count;

    start_req = 1;
    tick();
    start_req = 0;
    tick();
    checkOutput("latency_edge_n", hcount_axis_tvalid, 0);
    tick();
    checkOutput("latency_edge_n1", hcount_axis_tvalid, 1);
    rand_start = rstart;

    if (rst_mid) begin
      rst_at_11 = 1;
      n = 0;
      while (!rst_done && n < 200) begin
        tick();
        n++;
      end
      checkOutput("reset_reached_1_1", rst_done, 1);
      tick();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_tvalid", hcount_axis_tvalid, 0);
      checkOutput("reset_tdata", {hcount_axis_tdata, vcount_axis_tdata}, 0);
      checkOutput("reset_inflight", inflight, 0);
      checkOutput("reset_frame_done", fd_count - fd_before, 0);
    end else begin
      n = 0;
      while (model_busy && n < 1000) begin
        tick();
        n++;
      end
      checkOutput("frame_timeout", model_busy, 0);
      checkOutput("frame_done_count", fd_count - fd_before, 1);
      tick();
    end
    rand_start = 0;
    stall_en   = 0;
    rst_at_11  = 0;
  endtask

  initial begin
    aresetn      = 1'b0;
    start        = 1'b0;
    hready       = 1'b0;
    vready       = 1'b0;
    pixel_ret    = 1'b0;
    sphere_in    = '0;
    cylinders_in = '0;
    ready_pct    = 100;
    ret_delay    = 8;
    stall_left   = 0;
    fd_count     = 0;
    peak         = 0;
    checking     = 0;

    rst_req = 1;
    tick();
    tick();
    rst_req  = 0;
    checking = 1;
    tick();
    tick();

    // full-rate frame: credit limit must be reached exactly
    peak = 0;
    applyStimulus(100, 8, 0, 0, 0);
    checkOutput("inflight_peak", peak, MAXI);

    // backpressure held for three cycles at (2,1)
    applyStimulus(100, 8, 1, 0, 0);

    // random readiness, random latency, stray starts and live scene changes
    for (int f = 0; f < 3; f++)
      applyStimulus(60, int'($urandom_range(12, 1)), 0, 1, 0);

    // return with nothing outstanding
    force_ret = 1;
    tick();
    force_ret = 0;
    tick();
    checkOutput("stray_ret_inflight", inflight, 0);
    checkOutput("stray_ret_error", ret_error, 1);

    applyStimulus(75, 5, 0, 1, 0);

    // reset mid-frame, then a clean restart from (0,0)
    applyStimulus(100, 8, 0, 0, 1);
    applyStimulus(100, 8, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
